// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Sequences the VGA object multiplexer through five phases: title,
// countdown, play, pause and game over. It changes phase only on a frame
// boundary, so the screen never switches in the middle of a frame.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   startOfFrame one-cycle pulse per VGA frame
//   startKey     debounced start button (level)
//   pauseKey     debounced pause button (level)
//   p1Lose       player 1 lost (level or pulse)
//   p2Lose       player 2 lost (level or pulse)
//   enable_game  1 = game objects drawn, 0 = screen bitmap drawn
//   screenSel    bitmap select: 0 title, 1 countdown, 2 game over, 3 pause
//   countValue   countdown digit
//   winner       00 none, 01 player 1, 10 player 2, 11 draw
//   roundReset   one-cycle pulse that reinitialises the game objects
module game_flow_ctrl #(
  parameter int COUNT_FRAMES = 60,
  parameter int COUNT_STEPS  = 3,
  parameter int OVER_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       p1Lose,
  input  logic       p2Lose,
  output logic       enable_game,
  output logic [1:0] screenSel,
  output logic [2:0] countValue,
  output logic [1:0] winner,
  output logic       roundReset
);

  localparam int MAX_FRAMES = (COUNT_FRAMES > OVER_FRAMES) ? COUNT_FRAMES : OVER_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [CNT_W-1:0] OV_LAST = CNT_W'(OVER_FRAMES - 1);
  localparam logic [2:0]       STEPS   = 3'(COUNT_STEPS);

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             start_key_q, pause_key_q;
  logic             start_latch_q, start_latch_d;
  logic             pause_latch_q, pause_latch_d;
  logic             lose1_q, lose1_d;
  logic             lose2_q, lose2_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             enable_game_q, enable_game_d;
  logic [1:0]       screen_sel_q, screen_sel_d;
  logic [2:0]       count_value_q, count_value_d;
  logic [1:0]       winner_q, winner_d;
  logic             round_reset_q, round_reset_d;

  logic start_edge_s, pause_edge_s;
  logic pend_start_s, pend_pause_s;
  logic loss1_s, loss2_s;

  assign start_edge_s = startKey & ~start_key_q;
  assign pause_edge_s = pauseKey & ~pause_key_q;
  // An edge in the frame-boundary cycle itself counts for that frame.
  assign pend_start_s = start_latch_q | start_edge_s;
  assign pend_pause_s = pause_latch_q | pause_edge_s;
  assign loss1_s      = lose1_q | p1Lose;
  assign loss2_s      = lose2_q | p2Lose;

  // Next-state, latch, counter and output decode.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    count_value_d = count_value_q;
    winner_d      = winner_q;
    round_reset_d = 1'b0;
    // Key latches are dropped on every frame boundary, consumed or not.
    start_latch_d = startOfFrame ? 1'b0 : (start_latch_q | start_edge_s);
    pause_latch_d = startOfFrame ? 1'b0 : (pause_latch_q | pause_edge_s);
    lose1_d       = lose1_q;
    lose2_d       = lose2_q;
    if (state_q == ST_PLAY) begin
      lose1_d = loss1_s;
      lose2_d = loss2_s;
    end else begin
      lose1_d = lose1_q;
      lose2_d = lose2_q;
    end

    if (startOfFrame) begin
      case (state_q)
        ST_TITLE: begin
          if (pend_start_s) begin
            state_d       = ST_COUNTDOWN;
            count_value_d = STEPS;
            frame_cnt_d   = '0;
            winner_d      = 2'b00;
            round_reset_d = 1'b1;
            lose1_d       = 1'b0;
            lose2_d       = 1'b0;
          end else begin
            state_d = ST_TITLE;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_cnt_q == CD_LAST) begin
            frame_cnt_d = '0;
            if (count_value_q > 3'd1) begin
              count_value_d = count_value_q - 3'd1;
            end else begin
              count_value_d = 3'd0;
              state_d       = ST_PLAY;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // A loss outranks a pause requested in the same frame.
          if (loss1_s || loss2_s) begin
            state_d     = ST_OVER;
            winner_d    = {loss1_s, loss2_s};
            frame_cnt_d = '0;
          end else if (pend_pause_s) begin
            state_d     = ST_PAUSE;
            frame_cnt_d = '0;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_PAUSE: begin
          if (pend_pause_s) begin
            state_d     = ST_PLAY;
            frame_cnt_d = '0;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_OVER: begin
          if (frame_cnt_q == OV_LAST) begin
            state_d     = ST_TITLE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = ST_TITLE;
          frame_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Outputs follow the next state so they are registered with it.
    case (state_d)
      ST_TITLE:     begin enable_game_d = 1'b0; screen_sel_d = 2'd0; end
      ST_COUNTDOWN: begin enable_game_d = 1'b0; screen_sel_d = 2'd1; end
      ST_PLAY:      begin enable_game_d = 1'b1; screen_sel_d = 2'd0; end
      ST_PAUSE:     begin enable_game_d = 1'b0; screen_sel_d = 2'd3; end
      ST_OVER:      begin enable_game_d = 1'b0; screen_sel_d = 2'd2; end
      default:      begin enable_game_d = 1'b0; screen_sel_d = 2'd0; end
    endcase
  end

  // State, latches, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_TITLE;
      start_key_q   <= 1'b0;
      pause_key_q   <= 1'b0;
      start_latch_q <= 1'b0;
      pause_latch_q <= 1'b0;
      lose1_q       <= 1'b0;
      lose2_q       <= 1'b0;
      frame_cnt_q   <= '0;
      enable_game_q <= 1'b0;
      screen_sel_q  <= 2'd0;
      count_value_q <= 3'd0;
      winner_q      <= 2'b00;
      round_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_key_q   <= startKey;
      pause_key_q   <= pauseKey;
      start_latch_q <= start_latch_d;
      pause_latch_q <= pause_latch_d;
      lose1_q       <= lose1_d;
      lose2_q       <= lose2_d;
      frame_cnt_q   <= frame_cnt_d;
      enable_game_q <= enable_game_d;
      screen_sel_q  <= screen_sel_d;
      count_value_q <= count_value_d;
      winner_q      <= winner_d;
      round_reset_q <= round_reset_d;
    end
  end

  assign enable_game = enable_game_q;
  assign screenSel   = screen_sel_q;
  assign countValue  = count_value_q;
  assign winner      = winner_q;
  assign roundReset  = round_reset_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl with COUNT_FRAMES=2, COUNT_STEPS=3,
// OVER_FRAMES=3. One table row is one clock: inputs applied at the falling
// edge, outputs compared 1 ns after the following rising edge.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       startKey = 1'b0;
  logic       pauseKey = 1'b0;
  logic       p1Lose = 1'b0;
  logic       p2Lose = 1'b0;
  logic       enable_game;
  logic [1:0] screenSel;
  logic [2:0] countValue;
  logic [1:0] winner;
  logic       roundReset;

  int total = 0;
  int bad = 0;

  game_flow_ctrl #(
    .COUNT_FRAMES(2),
    .COUNT_STEPS (3),
    .OVER_FRAMES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .startKey    (startKey),
    .pauseKey    (pauseKey),
    .p1Lose      (p1Lose),
    .p2Lose      (p2Lose),
    .enable_game (enable_game),
    .screenSel   (screenSel),
    .countValue  (countValue),
    .winner      (winner),
    .roundReset  (roundReset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sof, sk, pk, l1, l2;
    logic       en;
    logic       sel_care;
    logic [1:0] sel;
    logic [2:0] cnt;
    logic [1:0] win;
    logic       rr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int sof, int sk, int pk, int l1, int l2,
                              int en, int selc, int sel, int cnt, int win, int rr);
    vec_t v;
    v.sof = sof[0]; v.sk = sk[0]; v.pk = pk[0]; v.l1 = l1[0]; v.l2 = l2[0];
    v.en = en[0]; v.sel_care = selc[0]; v.sel = sel[1:0];
    v.cnt = cnt[2:0]; v.win = win[1:0]; v.rr = rr[0];
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input int en, input int selc, input int sel,
                         input int cnt, input int win, input int rr);
    chk("enable_game", idx, int'(enable_game), en);
    if (selc != 0) chk("screenSel", idx, int'(screenSel), sel);
    chk("countValue", idx, int'(countValue), cnt);
    chk("winner", idx, int'(winner), win);
    chk("roundReset", idx, int'(roundReset), rr);
  endtask

  task automatic drive(input int sof, input int sk, input int pk, input int l1, input int l2);
    @(negedge clk);
    startOfFrame = sof[0]; startKey = sk[0]; pauseKey = pk[0];
    p1Lose = l1[0]; p2Lose = l2[0];
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_check(input int idx);
    startOfFrame = 1'b0; startKey = 1'b0; pauseKey = 1'b0;
    p1Lose = 1'b0; p2Lose = 1'b0;
    reset = 1'b1;
    #1;
    chk_all(idx, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // sof sk pk l1 l2 | en selc sel cnt win rr
    vq.push_back(mk(0,0,0,0,0, 0,1,0,0,0,0)); // idle title
    vq.push_back(mk(0,1,0,0,0, 0,1,0,0,0,0)); // start edge mid-frame
    vq.push_back(mk(0,1,0,0,0, 0,1,0,0,0,0)); // still waiting
    vq.push_back(mk(1,1,0,0,0, 0,1,1,3,0,1)); // frame: countdown
    vq.push_back(mk(0,0,0,0,0, 0,1,1,3,0,0)); // roundReset drops
    vq.push_back(mk(1,0,0,0,0, 0,1,1,3,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,1,1,3,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,2,0,0)); // 2 frames
    vq.push_back(mk(1,0,0,0,0, 0,1,1,2,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,1,0,0)); // 4 frames
    vq.push_back(mk(1,0,0,0,0, 0,1,1,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,0,0)); // 6 frames: play
    vq.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0)); // pause edge mid-frame
    vq.push_back(mk(1,0,1,0,0, 0,1,3,0,0,0)); // paused
    vq.push_back(mk(0,1,0,0,0, 0,1,3,0,0,0)); // start edge while paused
    vq.push_back(mk(1,1,0,0,0, 0,1,3,0,0,0)); // start ignored
    vq.push_back(mk(1,1,1,0,0, 1,0,0,0,0,0)); // pause edge on frame: resume
    vq.push_back(mk(0,1,0,0,1, 1,0,0,0,0,0)); // p2 loss pulse mid-frame
    vq.push_back(mk(1,1,0,0,0, 0,1,2,0,1,0)); // over, player 1 wins
    vq.push_back(mk(0,0,0,0,0, 0,1,2,0,1,0));
    vq.push_back(mk(1,1,0,0,0, 0,1,2,0,1,0)); // start edge in over ignored
    vq.push_back(mk(1,1,0,0,0, 0,1,2,0,1,0));
    vq.push_back(mk(1,1,0,0,0, 0,1,0,0,1,0)); // 3rd frame: title, winner held
    vq.push_back(mk(0,0,0,0,0, 0,1,0,0,1,0));
    vq.push_back(mk(1,1,0,0,0, 0,1,1,3,0,1)); // edge coincident with frame
    vq.push_back(mk(0,0,0,0,0, 0,1,1,3,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,3,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,2,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,2,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,0,0)); // play
    vq.push_back(mk(1,0,0,1,1, 0,1,2,0,3,0)); // both lose: draw
    vq.push_back(mk(1,0,0,0,0, 0,1,2,0,3,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,2,0,3,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0,3,0)); // title
    vq.push_back(mk(1,1,0,0,0, 0,1,1,3,0,1)); // start
    vq.push_back(mk(1,0,0,0,0, 0,1,1,3,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,2,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,2,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,1,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,0,0)); // play
    vq.push_back(mk(1,0,1,1,0, 0,1,2,0,2,0)); // loss beats pause: p2 wins
    vq.push_back(mk(0,0,0,0,1, 0,1,2,0,2,0)); // loss ignored in over

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(int'(vq[i].sof), int'(vq[i].sk), int'(vq[i].pk), int'(vq[i].l1), int'(vq[i].l2));
      chk_all(i, int'(vq[i].en), int'(vq[i].sel_care), int'(vq[i].sel),
              int'(vq[i].cnt), int'(vq[i].win), int'(vq[i].rr));
    end

    // Asynchronous reset out of OVER.
    async_reset_check(100);

    // Reset in the middle of the roundReset pulse.
    drive(1, 1, 0, 0, 0);
    chk_all(101, 0, 1, 1, 3, 0, 1);
    #2;
    async_reset_check(102);

    // Fresh start sequence after reset.
    drive(0, 0, 0, 0, 0);
    chk_all(103, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk_all(104, 0, 1, 1, 3, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk_all(105, 0, 1, 1, 3, 0, 0);
    begin
      int exp_cnt[6] = '{3, 2, 2, 1, 1, 0};
      for (int f = 0; f < 6; f++) begin
        drive(1, 0, 0, 0, 0);
        chk_all(110 + f, (f == 5) ? 1 : 0, (f == 5) ? 0 : 1, 1, exp_cnt[f], 0, 0);
      end
    end

    // Reset while playing.
    async_reset_check(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Frame-synchronous game-flow controller that sequences the VGA object multiplexer between title, countdown, play, pause and game-over phases. It drives the multiplexer's `enable_game` select and the screen-bitmap selector, and issues a one-cycle round reset to the game objects. All phase changes take effect only on a frame boundary, so the screen never tears mid-frame.

## Interface
Parameters:
- COUNT_FRAMES, 60: frames per countdown step.
- COUNT_STEPS, 3: countdown start value (1..7).
- OVER_FRAMES, 300: frames the game-over screen is held.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- startKey  in  1  level, debounced start button.
- pauseKey  in  1  level, debounced pause button.
- p1Lose  in  1  level/pulse: player 1 hearts exhausted or base 1 destroyed.
- p2Lose  in  1  level/pulse: player 2 hearts exhausted or base 2 destroyed.
- enable_game  out  1  1 = game objects drawn; 0 = screen bitmap drawn.
- screenSel  out  2  screen bitmap select: 0 title, 1 countdown, 2 game over, 3 pause.
- countValue  out  3  countdown digit shown on the countdown screen.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- roundReset  out  1  one-cycle pulse that reinitialises tanks, bricks and counters.

## Operation
- The FSM has five states: TITLE, COUNTDOWN, PLAY, PAUSE, OVER. Reset state is TITLE.
- Per-state outputs:
  - TITLE: enable_game=0, screenSel=0.
  - COUNTDOWN: enable_game=0, screenSel=1.
  - PLAY: enable_game=1.
  - PAUSE: enable_game=0, screenSel=3.
  - OVER: enable_game=0, screenSel=2.
- Key edges:
  - Rising edges of startKey and pauseKey are detected against a registered copy and latched.
  - pendStart = startLatch | startEdgeNow; pendPause is formed the same way.
  - Both latches clear on every startOfFrame, whether or not the edge was consumed.
- Loss events: in PLAY, p1Lose/p2Lose are OR-latched into lose1/lose2. The latches clear on entry to COUNTDOWN. Loss inputs are ignored in all other states.
- Transitions are evaluated only in cycles with startOfFrame=1:
  - TITLE -> COUNTDOWN when pendStart. Sets countValue=COUNT_STEPS, frameCnt=0, winner=00.
  - COUNTDOWN: frameCnt counts startOfFrame pulses.
    - At frameCnt==COUNT_FRAMES-1: frameCnt<=0.
    - If countValue>1, countValue decrements; otherwise countValue<=0 and the state goes to PLAY.
  - PLAY -> OVER when (lose1|p1Lose) or (lose2|p2Lose). winner = {p1 lost, p2 lost} mapped as: only p2 lost -> 01; only p1 lost -> 10; both lost -> 11.
  - PLAY -> PAUSE when pendPause, provided no loss is pending. Loss takes priority over pause.
  - PAUSE -> PLAY when pendPause. pendStart is ignored in PAUSE.
  - OVER: frameCnt counts; at frameCnt==OVER_FRAMES-1 the state goes to TITLE and winner is held until the next COUNTDOWN entry. pendStart is ignored in OVER.
- Counter widths:
  - frameCnt width = $clog2(max(COUNT_FRAMES,OVER_FRAMES)).
  - frameCnt resets to 0 on every state entry and never wraps.
- roundReset is asserted for exactly the one clock following the TITLE->COUNTDOWN transition.

## Timing
- All outputs are registered.
- A transition decided in the startOfFrame cycle N is visible on the outputs at cycle N+1.
- A key edge or loss arriving in the same cycle as startOfFrame is honoured in that frame.
- A key edge arriving between frames is honoured at the next startOfFrame only.
- Countdown lasts exactly COUNT_STEPS×COUNT_FRAMES frames. The OVER screen lasts OVER_FRAMES frames.
- Reset values: enable_game=0, screenSel=0, countValue=0, winner=00, roundReset=0. All latches and counters are 0 and the state is TITLE.
- Reset asserted mid-operation, including during a roundReset pulse, returns the block to these values immediately (asynchronous).
- A held key produces no further edges; a new edge requires release and re-press.

## Test plan
- Use COUNT_FRAMES=2, COUNT_STEPS=3 throughout.
- Start sequence: startKey edge in TITLE, then startOfFrame.
  - Next cycle: screenSel=1, countValue=3, roundReset=1 for one cycle.
  - After 2 frames countValue=2, after 4 frames countValue=1.
  - After 6 frames: enable_game=1, countValue=0.
- Edge timing: startKey edge mid-frame -> no change until the next startOfFrame. Edge coincident with startOfFrame -> transition in that same frame.
- Pause: in PLAY, pauseKey edge -> screenSel=3, enable_game=0. Second edge -> enable_game=1. startKey while paused -> no effect.
- Loss handling:
  - p2Lose pulse between frames -> at the next startOfFrame, OVER with winner=01.
  - p1Lose and p2Lose in the same frame -> winner=11.
  - Loss plus pause in the same frame -> OVER.
- Game-over exit (OVER_FRAMES=3): OVER returns to TITLE after exactly 3 startOfFrame pulses. startKey during OVER is ignored. winner is retained until the next start.
- Reset during COUNTDOWN and during PLAY -> all outputs return to reset values asynchronously; a fresh start sequence behaves as the start-sequence scenario above.
